// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and field widths for the I2C transaction sequencer
package i2c_pkg;
   localparam int I2C_ADDR_W = 7;
   localparam int I2C_LEN_W = 5;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      START = 3'd2,
      RUN   = 3'd3,
      FLUSH = 3'd4
   } state_t;
endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// i2c_txn_sequencer_if: host command/data channels plus the I2C master-core control signals
interface i2c_txn_sequencer_if;
   import i2c_pkg::*;
   logic                  cmd_valid, cmd_ready, cmd_rw;
   logic [I2C_ADDR_W-1:0] cmd_addr;
   logic [I2C_LEN_W-1:0]  cmd_len;
   logic                  wr_valid, wr_ready;
   logic [7:0]            wr_data;
   logic                  rd_valid, rd_ready;
   logic [7:0]            rd_data;
   logic                  busy, err;
   logic                  m_ena, m_rw;
   logic [I2C_ADDR_W-1:0] m_address;
   logic [I2C_LEN_W-1:0]  m_n_byte;
   logic [7:0]            m_data_in, m_data_out;
   logic                  m_byte_req, m_valid, m_done;
   modport slave (
      input  cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
             m_byte_req, m_valid, m_data_out, m_done,
      output cmd_ready, wr_ready, rd_valid, rd_data, busy, err,
             m_ena, m_rw, m_address, m_n_byte, m_data_in
   );
   modport master (
      output cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
             m_byte_req, m_valid, m_data_out, m_done,
      input  cmd_ready, wr_ready, rd_valid, rd_data, busy, err,
             m_ena, m_rw, m_address, m_n_byte, m_data_in
   );
endinterface

// File: rtl/i2c_byte_fifo.sv
// i2c_byte_fifo: byte FIFO with combinational head; push+pop together is always legal
module i2c_byte_fifo #(
   parameter int DEPTH = 16,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          do_push, do_pop;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign do_push = push & (~full | pop);
   assign do_pop = pop & (~empty | push);
   assign dout = mem[rp];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk)
      if (do_push) mem[wp] <= din;
endmodule

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: queues host commands and bytes, sequences one I2C master transaction at a time
module i2c_txn_sequencer import i2c_pkg::*; #(
   parameter int DEPTH = 16,
   parameter int AW = 4
) (
   input logic clk,
   input logic rst_n,
   i2c_txn_sequencer_if.slave bus
);
   state_t               state, state_nx;
   logic [I2C_LEN_W-1:0] bytes_left, bl_nx;
   logic [AW:0]          wcount, rcount;
   logic                 wfull, wempty, rfull, rempty;
   logic                 cmd_acc, in_run, wr_ev, rd_ev, fl_ev, stray;
   logic                 wpush, wpop, rpush, rpop, fifo_ok, set_err;
   assign cmd_acc = bus.cmd_valid & bus.cmd_ready;
   assign in_run = state == RUN;
   assign wr_ev = in_run & ~bus.m_rw & bus.m_byte_req & (bytes_left != '0);
   assign rd_ev = in_run & bus.m_rw & bus.m_valid & (bytes_left != '0);
   assign fl_ev = (state == FLUSH) & (bytes_left != '0);
   assign stray = (bus.m_byte_req | bus.m_valid) & (~in_run | (bytes_left == '0));
   assign wpush = bus.wr_valid & ~wfull;
   assign wpop = wr_ev | fl_ev;
   assign rpush = rd_ev;
   assign rpop = bus.rd_ready & ~rempty;
   assign bl_nx = bytes_left - I2C_LEN_W'(wpop | rpush);
   // Only launch once the whole transfer fits, so the master never starves or overflows
   assign fifo_ok = bus.m_rw ? (DEPTH - int'(rcount) >= int'(bytes_left))
                             : (int'(wcount) >= int'(bytes_left));
   assign set_err = stray | (wpop & wempty & ~wpush) | (rpush & rfull & ~rpop)
                  | (in_run & bus.m_done & (bl_nx != '0));
   assign bus.cmd_ready = state == IDLE;
   assign bus.busy = state != IDLE;
   assign bus.m_ena = (state == START) | in_run;
   assign bus.wr_ready = ~wfull;
   assign bus.rd_valid = ~rempty;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (cmd_acc && bus.cmd_len != '0) ? WAIT : IDLE;
         WAIT:    state_nx = fifo_ok ? START : WAIT;
         START:   state_nx = RUN;
         RUN:     state_nx = !bus.m_done ? RUN : (bl_nx == '0 || bus.m_rw) ? IDLE : FLUSH;
         FLUSH:   state_nx = (bytes_left <= I2C_LEN_W'(1)) ? IDLE : FLUSH;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         bytes_left <= '0;
         bus.m_rw <= 1'b0;
         bus.m_address <= '0;
         bus.m_n_byte <= '0;
         bus.err <= 1'b0;
      end else begin
         state <= state_nx;
         bytes_left <= cmd_acc ? bus.cmd_len : bl_nx;
         bus.err <= cmd_acc ? (bus.cmd_len == '0) : (bus.err | set_err);
         if (cmd_acc) begin
            bus.m_rw <= bus.cmd_rw;
            bus.m_address <= bus.cmd_addr;
            bus.m_n_byte <= bus.cmd_len;
         end
      end
   end
   i2c_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_wfifo (
      .clk(clk), .rst_n(rst_n), .push(wpush), .pop(wpop), .din(bus.wr_data),
      .dout(bus.m_data_in), .full(wfull), .empty(wempty), .count(wcount)
   );
   i2c_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rfifo (
      .clk(clk), .rst_n(rst_n), .push(rpush), .pop(rpop), .din(bus.m_data_out),
      .dout(bus.rd_data), .full(rfull), .empty(rempty), .count(rcount)
   );
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: directed plus randomized transactions checked against queue-based FIFO model
module tb_i2c_txn_sequencer;
   localparam int DEPTH = 16;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [7:0] wq[$];
   logic [7:0] rq[$];

   i2c_txn_sequencer_if bus();
   i2c_txn_sequencer #(.DEPTH(DEPTH), .AW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic quiet();
      bus.cmd_valid = 0; bus.wr_valid = 0; bus.rd_ready = 0;
      bus.m_byte_req = 0; bus.m_valid = 0; bus.m_done = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      quiet();
   endtask

   task automatic check_fifos(input string tag);
      chk({tag, ".wr_ready"}, bus.wr_ready, wq.size() < DEPTH);
      chk({tag, ".rd_valid"}, bus.rd_valid, rq.size() != 0);
      if (rq.size() != 0) chk({tag, ".rd_data"}, bus.rd_data, rq[0]);
      if (wq.size() != 0) chk({tag, ".m_data_in"}, bus.m_data_in, wq[0]);
   endtask

   task automatic push_w(input logic [7:0] b);
      bus.wr_valid = 1; bus.wr_data = b;
      tick();
      wq.push_back(b);
   endtask

   task automatic send_cmd(input logic rw, input logic [6:0] addr, input logic [4:0] len);
      chk("cmd_ready", bus.cmd_ready, 1);
      bus.cmd_valid = 1; bus.cmd_rw = rw; bus.cmd_addr = addr; bus.cmd_len = len;
      tick();
   endtask

   task automatic start_txn(input logic rw, input logic [6:0] addr, input logic [4:0] len);
      send_cmd(rw, addr, len);
      chk("acc.m_ena", bus.m_ena, 0);
      chk("acc.busy", bus.busy, 1);
      chk("acc.err", bus.err, 0);
      tick();
      chk("start.m_ena", bus.m_ena, 1);
      chk("start.m_rw", bus.m_rw, rw);
      chk("start.m_address", bus.m_address, addr);
      chk("start.m_n_byte", bus.m_n_byte, len);
      tick();
      chk("run.m_ena", bus.m_ena, 1);
   endtask

   task automatic breq(input logic also_push, input logic [7:0] b);
      chk("breq.m_data_in", bus.m_data_in, wq[0]);
      bus.m_byte_req = 1;
      bus.wr_valid = also_push; bus.wr_data = b;
      tick();
      void'(wq.pop_front());
      if (also_push) wq.push_back(b);
   endtask

   task automatic mval(input logic [7:0] b);
      bus.m_valid = 1; bus.m_data_out = b;
      tick();
      rq.push_back(b);
   endtask

   task automatic hpop();
      chk("hpop.rd_data", bus.rd_data, rq[0]);
      bus.rd_ready = 1;
      tick();
      void'(rq.pop_front());
   endtask

   task automatic done();
      bus.m_done = 1;
      tick();
   endtask

   task automatic rand_txn();
      logic rw;
      int len;
      logic [6:0] addr;
      rw = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      addr = 7'($urandom);
      if (rw) while (DEPTH - rq.size() < len) hpop();
      else while (wq.size() < len) push_w(8'($urandom));
      start_txn(rw, addr, 5'(len));
      for (int i = 0; i < len; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         if (rw) mval(8'($urandom));
         else breq(($urandom_range(0, 1) == 1) && (wq.size() < DEPTH), 8'($urandom));
      end
      done();
      chk("rnd.busy", bus.busy, 0);
      chk("rnd.err", bus.err, 0);
      chk("rnd.m_ena", bus.m_ena, 0);
      check_fifos("rnd");
      repeat ($urandom_range(0, 3)) if (rq.size() != 0) hpop();
   endtask

   initial begin
      quiet();
      bus.cmd_rw = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
      bus.wr_data = '0; bus.m_data_out = '0;
      repeat (2) tick();
      rst_n = 1;
      chk("rst.cmd_ready", bus.cmd_ready, 1);
      chk("rst.wr_ready", bus.wr_ready, 1);
      chk("rst.rd_valid", bus.rd_valid, 0);
      chk("rst.busy", bus.busy, 0);
      chk("rst.m_ena", bus.m_ena, 0);
      chk("rst.err", bus.err, 0);
      chk("rst.m_rw", bus.m_rw, 0);
      chk("rst.m_address", bus.m_address, 0);
      chk("rst.m_n_byte", bus.m_n_byte, 0);

      push_w(8'hA1); push_w(8'hB2); push_w(8'hC3);
      check_fifos("w3.queued");
      start_txn(0, 7'h50, 3);
      repeat (3) breq(0, 8'h00);
      done();
      chk("w3.busy", bus.busy, 0);
      chk("w3.err", bus.err, 0);
      chk("w3.m_ena", bus.m_ena, 0);
      check_fifos("w3.end");

      push_w(8'($urandom)); push_w(8'($urandom));
      send_cmd(0, 7'h11, 4);
      repeat (3) begin
         chk("stall.m_ena", bus.m_ena, 0);
         chk("stall.busy", bus.busy, 1);
         tick();
      end
      push_w(8'($urandom)); push_w(8'($urandom));
      chk("stall.last", bus.m_ena, 0);
      tick();
      chk("stall.go", bus.m_ena, 1);
      tick();
      repeat (4) breq(0, 8'h00);
      done();
      chk("stall.err", bus.err, 0);
      check_fifos("stall.end");

      start_txn(1, 7'h68, 2);
      mval(8'h3C);
      chk("r2.rd_valid", bus.rd_valid, 1);
      chk("r2.rd_data0", bus.rd_data, 8'h3C);
      mval(8'h7E);
      done();
      chk("r2.busy", bus.busy, 0);
      chk("r2.err", bus.err, 0);
      hpop();
      chk("r2.rd_data1", bus.rd_data, 8'h7E);
      hpop();
      chk("r2.empty", bus.rd_valid, 0);

      start_txn(1, 7'h22, 15);
      repeat (15) mval(8'($urandom));
      done();
      check_fifos("space.filled");
      send_cmd(1, 7'h23, 2);
      repeat (3) begin
         chk("space.wait", bus.m_ena, 0);
         tick();
      end
      hpop();
      chk("space.last", bus.m_ena, 0);
      tick();
      chk("space.go", bus.m_ena, 1);
      tick();
      repeat (2) mval(8'($urandom));
      done();
      chk("space.err", bus.err, 0);
      while (rq.size() != 0) hpop();
      chk("space.drained", bus.rd_valid, 0);

      repeat (5) push_w(8'($urandom));
      start_txn(0, 7'h2A, 5);
      repeat (2) breq(0, 8'h00);
      done();
      chk("early.err", bus.err, 1);
      chk("early.m_ena", bus.m_ena, 0);
      chk("early.flush", bus.busy, 1);
      for (int i = 0; i < 8 && bus.busy; i++) tick();
      chk("early.idle", bus.busy, 0);
      chk("early.err_sticky", bus.err, 1);
      repeat (3) void'(wq.pop_front());
      push_w(8'h5A);
      check_fifos("early.marker");
      start_txn(0, 7'h31, 1);
      breq(0, 8'h00);
      done();
      chk("clear.err", bus.err, 0);

      send_cmd(0, 7'h10, 0);
      chk("len0.err", bus.err, 1);
      chk("len0.busy", bus.busy, 0);
      tick();
      chk("len0.idle", bus.busy, 0);

      for (int t = 0; t < 24; t++) rand_txn();

      bus.m_byte_req = 1;
      tick();
      chk("stray_idle.err", bus.err, 1);
      check_fifos("stray_idle");
      while (wq.size() < 2) push_w(8'($urandom));
      start_txn(0, 7'h44, 2);
      repeat (2) breq(0, 8'h00);
      bus.m_byte_req = 1;
      tick();
      chk("stray_zero.err", bus.err, 1);
      check_fifos("stray_zero");
      done();
      chk("stray_zero.idle", bus.busy, 0);

      while (DEPTH - rq.size() < 1) hpop();
      start_txn(1, 7'h12, 1);
      mval(8'($urandom));
      done();
      while (wq.size() < 3) push_w(8'($urandom));
      start_txn(0, 7'h40, 3);
      breq(0, 8'h00);
      rst_n = 0;
      tick();
      rst_n = 1;
      wq.delete();
      rq.delete();
      chk("midrst.m_ena", bus.m_ena, 0);
      chk("midrst.cmd_ready", bus.cmd_ready, 1);
      chk("midrst.busy", bus.busy, 0);
      chk("midrst.err", bus.err, 0);
      check_fifos("midrst");
      push_w(8'h96);
      check_fifos("midrst.after");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
